// File: rtl/mult_8x8_err_monitor.sv
// mult_8x8_err_monitor: accumulates error statistics of an approximate 8x8 multiplier over a programmed run
module mult_8x8_err_monitor #(
  parameter int CNT_W = 16,
  parameter int SUM_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [15:0]      r_apx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SUM_W-1:0] sum_ed,
  output logic [15:0]      max_ed,
  output logic [7:0]       max_a,
  output logic [7:0]       max_b
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] tgt_q, tgt_d, cnt_q, cnt_d, cnt_inc, err_q, err_d;
  logic             s1_v_q, s1_v_d, s2_v_q, s2_v_d, s2_ne_q, s2_ne_d;
  logic [7:0]       s1_a_q, s1_a_d, s1_b_q, s1_b_d, s2_a_q, s2_a_d, s2_b_q, s2_b_d;
  logic [15:0]      s1_p_q, s1_p_d, s1_r_q, s1_r_d, s2_ed_q, s2_ed_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SUM_W:0]   sum_ext;
  logic [15:0]      max_q, max_d;
  logic [7:0]       ma_q, ma_d, mb_q, mb_d;
  logic             xfer, clr;

  assign in_ready = state_q == RUN;
  assign busy     = state_q == RUN || state_q == DRAIN;
  assign done     = state_q == DONE;
  assign err_cnt  = err_q;
  assign sum_ed   = sum_q;
  assign max_ed   = max_q;
  assign max_a    = ma_q;
  assign max_b    = mb_q;
  assign xfer     = in_valid && in_ready;
  assign clr      = start && (state_q == IDLE || state_q == DONE);
  assign cnt_inc  = cnt_q + 1'b1;

  // Run control; DRAIN exits once S1 is empty so the last sample's accumulate coincides with entering DONE
  always_comb begin
    state_d = state_q;
    tgt_d   = clr ? n_samples : tgt_q;
    cnt_d   = clr ? '0 : xfer ? cnt_inc : cnt_q;
    if (clr)
      state_d = n_samples == '0 ? DONE : RUN;
    else if (state_q == RUN && xfer && cnt_inc == tgt_q)
      state_d = DRAIN;
    else if (state_q == DRAIN && !s1_v_q)
      state_d = DONE;
  end

  // Two-stage pipeline: exact product, then absolute error distance
  always_comb begin
    s1_v_d  = xfer;
    s1_a_d  = a;
    s1_b_d  = b;
    s1_r_d  = r_apx;
    s1_p_d  = 16'(a) * 16'(b);
    s2_v_d  = s1_v_q;
    s2_a_d  = s1_a_q;
    s2_b_d  = s1_b_q;
    s2_ed_d = s1_p_q >= s1_r_q ? s1_p_q - s1_r_q : s1_r_q - s1_p_q;
    s2_ne_d = s2_ed_d != 16'd0;
  end

  // Statistics accumulation with saturating sum and first-wins maximum
  always_comb begin
    sum_ext = {1'b0, sum_q} + (SUM_W + 1)'(s2_ed_q);
    err_d   = clr ? '0 : s2_v_q ? err_q + CNT_W'(s2_ne_q) : err_q;
    sum_d   = clr ? '0 : !s2_v_q ? sum_q : sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
    max_d   = clr ? '0 : (s2_v_q && s2_ed_q > max_q) ? s2_ed_q : max_q;
    ma_d    = clr ? '0 : (s2_v_q && s2_ed_q > max_q) ? s2_a_q : ma_q;
    mb_d    = clr ? '0 : (s2_v_q && s2_ed_q > max_q) ? s2_b_q : mb_q;
  end

  // State, pipeline and statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      cnt_q   <= '0;
      s1_v_q  <= 1'b0;
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      s1_p_q  <= '0;
      s1_r_q  <= '0;
      s2_v_q  <= 1'b0;
      s2_a_q  <= '0;
      s2_b_q  <= '0;
      s2_ed_q <= '0;
      s2_ne_q <= 1'b0;
      err_q   <= '0;
      sum_q   <= '0;
      max_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      s1_v_q  <= s1_v_d;
      s1_a_q  <= s1_a_d;
      s1_b_q  <= s1_b_d;
      s1_p_q  <= s1_p_d;
      s1_r_q  <= s1_r_d;
      s2_v_q  <= s2_v_d;
      s2_a_q  <= s2_a_d;
      s2_b_q  <= s2_b_d;
      s2_ed_q <= s2_ed_d;
      s2_ne_q <= s2_ne_d;
      err_q   <= err_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
    end
  end
endmodule

// File: tb/tb_mult_8x8_err_monitor.sv
// tb_mult_8x8_err_monitor: directed self-checking bench for the error monitor
module tb_mult_8x8_err_monitor;
  logic        clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic [15:0] n_samples = 0, r_apx = 0;
  logic [7:0]  a = 0, b = 0;
  logic        in_ready, busy, done;
  logic [15:0] err_cnt, max_ed;
  logic [16:0] sum_ed;
  logic [7:0]  max_a, max_b;
  int vectors = 0, miscompares = 0;

  mult_8x8_err_monitor #(.CNT_W(16), .SUM_W(17)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .r_apx(r_apx),
    .busy(busy), .done(done), .err_cnt(err_cnt), .sum_ed(sum_ed),
    .max_ed(max_ed), .max_a(max_a), .max_b(max_b)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [15:0] r);
    in_valid = 1; a = x; b = y; r_apx = r;
    tick;
    in_valid = 0;
  endtask

  task automatic kick(input logic [15:0] n);
    start = 1; n_samples = n;
    tick;
    start = 0;
  endtask

  task automatic wait_done;
    for (int i = 0; i < 10 && done !== 1'b1; i++) tick;
  endtask

  task automatic test_reset;
    rst_n = 0;
    tick;
    vectors++;
    if ({in_ready, busy, done} !== 3'b000) begin
      miscompares++; $display("FAIL reset_ctrl: got %b want 000", {in_ready, busy, done});
    end
    vectors++;
    if ({err_cnt, sum_ed, max_ed, max_a, max_b} !== 65'd0) begin
      miscompares++; $display("FAIL reset_stats: got %h want 0", {err_cnt, sum_ed, max_ed, max_a, max_b});
    end
    #2 rst_n = 1;
    tick;
  endtask

  task automatic test_exact;
    logic [7:0] x, y;
    kick(10);
    vectors++;
    if ({busy, in_ready, done} !== 3'b110 || {err_cnt, sum_ed, max_ed} !== 49'd0) begin
      miscompares++; $display("FAIL exact_start: ctrl %b stats %h want 110/0", {busy, in_ready, done}, {err_cnt, sum_ed, max_ed});
    end
    for (int i = 0; i < 10; i++) begin
      x = 8'($urandom); y = 8'($urandom);
      send(x, y, 16'(x) * 16'(y));
    end
    vectors++;
    if ({done, in_ready, busy} !== 3'b001) begin
      miscompares++; $display("FAIL exact_t1: got %b want 001", {done, in_ready, busy});
    end
    tick;
    vectors++;
    if ({done, busy} !== 2'b01) begin
      miscompares++; $display("FAIL exact_t2: got %b want 01", {done, busy});
    end
    tick;
    vectors++;
    if ({done, busy} !== 2'b10) begin
      miscompares++; $display("FAIL exact_t3: got %b want 10", {done, busy});
    end
    vectors++;
    if ({err_cnt, sum_ed, max_ed} !== 49'd0) begin
      miscompares++; $display("FAIL exact_stats: got %h want 0", {err_cnt, sum_ed, max_ed});
    end
  endtask

  task automatic test_mixed;
    kick(2);
    send(255, 255, 16'hFE00);
    send(3, 3, 16'd11);
    wait_done;
    vectors++;
    if ({err_cnt, sum_ed, max_ed, max_a, max_b} !== {16'd2, 17'd3, 16'd2, 8'd3, 8'd3}) begin
      miscompares++; $display("FAIL mixed_stats: got %h want %h", {err_cnt, sum_ed, max_ed, max_a, max_b}, {16'd2, 17'd3, 16'd2, 8'd3, 8'd3});
    end
  endtask

  task automatic test_saturation;
    kick(3);
    vectors++;
    if ({done, err_cnt, sum_ed, max_ed} !== 50'd0) begin
      miscompares++; $display("FAIL sat_restart: got %h want 0", {done, err_cnt, sum_ed, max_ed});
    end
    for (int i = 0; i < 3; i++) send(255, 255, 16'd0);
    wait_done;
    vectors++;
    if ({err_cnt, sum_ed, max_ed, max_a, max_b} !== {16'd3, 17'h1FFFF, 16'd65025, 8'd255, 8'd255}) begin
      miscompares++; $display("FAIL sat_stats: got %h want %h", {err_cnt, sum_ed, max_ed, max_a, max_b}, {16'd3, 17'h1FFFF, 16'd65025, 8'd255, 8'd255});
    end
  endtask

  task automatic test_zero;
    kick(0);
    vectors++;
    if ({done, busy, in_ready} !== 3'b100 || {err_cnt, sum_ed, max_ed, max_a, max_b} !== 65'd0) begin
      miscompares++; $display("FAIL zero_run: ctrl %b stats %h want 100/0", {done, busy, in_ready}, {err_cnt, sum_ed, max_ed, max_a, max_b});
    end
    in_valid = 1; a = 9; b = 9; r_apx = 0;
    tick; tick;
    in_valid = 0;
    vectors++;
    if ({done, busy, in_ready} !== 3'b100 || {err_cnt, sum_ed} !== 33'd0) begin
      miscompares++; $display("FAIL zero_hold: ctrl %b stats %h want 100/0", {done, busy, in_ready}, {err_cnt, sum_ed});
    end
  endtask

  task automatic test_backpressure;
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    logic [7:0] sa[5] = '{2, 4, 10, 7, 99};
    logic [7:0] sb[5] = '{3, 1, 10, 7, 99};
    logic [15:0] sr[5] = '{5, 3, 100, 50, 0};
    int k = 0, xfers = 0;
    kick(4);
    vectors++;
    if ({done, busy} !== 2'b01) begin
      miscompares++; $display("FAIL bp_done_drop: got %b want 01", {done, busy});
    end
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i] != 0; a = sa[k]; b = sb[k]; r_apx = sr[k];
      if (i == 2) begin start = 1; n_samples = 1; end
      if (in_valid && in_ready) begin xfers++; k++; end
      tick;
      start = 0;
    end
    in_valid = 1; a = sa[4]; b = sb[4]; r_apx = sr[4];
    if (in_ready) xfers++;
    vectors++;
    if ({in_ready, busy} !== 2'b01) begin
      miscompares++; $display("FAIL bp_ready_low: got %b want 01", {in_ready, busy});
    end
    tick;
    in_valid = 0;
    vectors++;
    if (done !== 1'b0) begin
      miscompares++; $display("FAIL bp_t2: done %b want 0", done);
    end
    tick;
    vectors++;
    if ({done, busy} !== 2'b10) begin
      miscompares++; $display("FAIL bp_t3: got %b want 10", {done, busy});
    end
    vectors++;
    if (xfers !== 4) begin
      miscompares++; $display("FAIL bp_xfers: got %0d want 4", xfers);
    end
    vectors++;
    if ({err_cnt, sum_ed, max_ed, max_a, max_b} !== {16'd3, 17'd3, 16'd1, 8'd2, 8'd3}) begin
      miscompares++; $display("FAIL bp_stats_tie: got %h want %h", {err_cnt, sum_ed, max_ed, max_a, max_b}, {16'd3, 17'd3, 16'd1, 8'd2, 8'd3});
    end
  endtask

  task automatic test_reset_mid;
    kick(5);
    send(10, 10, 0);
    send(10, 10, 0);
    tick;
    vectors++;
    if ({err_cnt, sum_ed} !== {16'd1, 17'd100}) begin
      miscompares++; $display("FAIL mid_partial: got %h want %h", {err_cnt, sum_ed}, {16'd1, 17'd100});
    end
    #3 rst_n = 0;
    #1;
    vectors++;
    if ({in_ready, busy, done} !== 3'b000 || {err_cnt, sum_ed, max_ed, max_a, max_b} !== 65'd0) begin
      miscompares++; $display("FAIL mid_reset: ctrl %b stats %h want 000/0", {in_ready, busy, done}, {err_cnt, sum_ed, max_ed, max_a, max_b});
    end
    tick;
    #2 rst_n = 1;
    tick; tick;
    vectors++;
    if ({in_ready, busy, done} !== 3'b000 || {err_cnt, sum_ed} !== 33'd0) begin
      miscompares++; $display("FAIL mid_idle: ctrl %b stats %h want 000/0", {in_ready, busy, done}, {err_cnt, sum_ed});
    end
    kick(2);
    send(1, 1, 0);
    send(2, 2, 4);
    wait_done;
    vectors++;
    if ({done, err_cnt, sum_ed, max_ed, max_a, max_b} !== {1'b1, 16'd1, 17'd1, 16'd1, 8'd1, 8'd1}) begin
      miscompares++; $display("FAIL mid_fresh: got %h want %h", {done, err_cnt, sum_ed, max_ed, max_a, max_b}, {1'b1, 16'd1, 17'd1, 16'd1, 8'd1, 8'd1});
    end
  endtask

  initial begin
    test_reset;
    test_exact;
    test_mixed;
    test_saturation;
    test_zero;
    test_backpressure;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
